// File: rtl/alu_seq.sv
// Sequential PIC-style ALU: single-cycle ops plus an optional iterative shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the MUL state and multiplier; otherwise opcode 14 acts as reserved.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int HALF  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_w,
    input  logic [WIDTH-1:0] op_lf,
    input  logic             c_in,
    input  logic             d,
    input  logic             dest_wr_en,
    input  logic             status_wr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             w_wr_en,
    output logic             f_wr_en,
    output logic             z,
    output logic             dc,
    output logic             c,
    output logic             z_wr_en,
    output logic             dc_wr_en,
    output logic             c_wr_en
);

    localparam int HW = WIDTH / 2;
    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_AND    = 4'd1;
    localparam logic [3:0] OP_CLR    = 4'd2;
    localparam logic [3:0] OP_COM    = 4'd3;
    localparam logic [3:0] OP_DEC    = 4'd4;
    localparam logic [3:0] OP_INC    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_PASSLF = 4'd7;
    localparam logic [3:0] OP_PASSW  = 4'd8;
    localparam logic [3:0] OP_RLF    = 4'd9;
    localparam logic [3:0] OP_RRF    = 4'd10;
    localparam logic [3:0] OP_SUB    = 4'd11;
    localparam logic [3:0] OP_SWAPF  = 4'd12;
    localparam logic [3:0] OP_XOR    = 4'd13;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL    = 4'd14;
    localparam int         CW        = $clog2(WIDTH);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             dc;
        logic             c;
        logic             z_we;
        logic             dc_we;
        logic             c_we;
    } alu_res_t;

    function automatic alu_res_t alu_eval(input logic [3:0] f_op, input logic [WIDTH-1:0] w,
                                          input logic [WIDTH-1:0] lf, input logic cin);
        alu_res_t   r;
        logic [WIDTH:0] sum;
        r   = '0;
        sum = {1'b0, w} + {1'b0, lf};
        case (f_op)
            OP_ADD: begin
                r.res = sum[WIDTH-1:0];
                r.c   = sum[WIDTH];
                // a + b overflows the low half exactly when a > ~b
                r.dc  = (w[HALF-1:0] > ~lf[HALF-1:0]);
                r.z_we = 1'b1; r.dc_we = 1'b1; r.c_we = 1'b1;
            end
            OP_AND:    begin r.res = w & lf;            r.z_we = 1'b1; end
            OP_CLR:    begin r.res = '0;                r.z_we = 1'b1; end
            OP_COM:    begin r.res = ~lf;               r.z_we = 1'b1; end
            OP_DEC:    begin r.res = lf - WIDTH'(1);    r.z_we = 1'b1; end
            OP_INC:    begin r.res = lf + WIDTH'(1);    r.z_we = 1'b1; end
            OP_OR:     begin r.res = w | lf;            r.z_we = 1'b1; end
            OP_PASSLF: begin r.res = lf;                r.z_we = 1'b1; end
            OP_PASSW:  begin r.res = w;                 r.z_we = 1'b1; end
            OP_RLF:    begin r.res = {lf[WIDTH-2:0], cin}; r.c = lf[WIDTH-1]; r.c_we = 1'b1; end
            OP_RRF:    begin r.res = {cin, lf[WIDTH-1:1]}; r.c = lf[0];       r.c_we = 1'b1; end
            OP_SUB: begin
                r.res = lf - w;
                r.c   = (lf >= w);
                r.dc  = (lf[HALF-1:0] >= w[HALF-1:0]);
                r.z_we = 1'b1; r.dc_we = 1'b1; r.c_we = 1'b1;
            end
            OP_SWAPF:  r.res = {lf[HW-1:0], lf[WIDTH-1:HW]};
            OP_XOR:    begin r.res = w ^ lf;            r.z_we = 1'b1; end
            default:   r = '0;
        endcase
        r.z = r.z_we & (r.res == '0);
        return r;
    endfunction

    state_t           state, state_nx;
    logic             accept;
    alu_res_t         ev;
    logic [WIDTH-1:0] res_p1;
    logic             z_p1, dc_p1, c_p1;
    logic             z_we_p1, dc_we_p1, c_we_p1, w_we_p1, f_we_p1;

    assign ev = alu_eval(op, op_w, op_lf, c_in);

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   hi_p1, mcand_p1;
    logic [2*WIDTH-1:0] acc_p1, acc_nx;
    logic [WIDTH:0]     part;
    logic [CW-1:0]      cnt_p1;
    logic               st_p1, mul_last, is_mul;

    // acc holds {partial product, unconsumed multiplier bits}; one bit retired per cycle
    assign part     = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (acc_p1[0] ? {1'b0, mcand_p1} : '0);
    assign acc_nx   = {part, acc_p1[WIDTH-1:1]};
    assign mul_last = (cnt_p1 == CW'(WIDTH - 1));
    assign is_mul   = (op == OP_MUL);
    assign result_hi = hi_p1;
`else
    assign result_hi = '0;
`endif

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_nx = ST_IDLE;
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL:  if (mul_last) state_nx = ST_HOLD;
`endif
            default: state_nx = ST_IDLE;
        endcase
        accept = in_valid & in_ready;
`ifdef ALU_SEQ_MUL_EN
        if (accept) state_nx = is_mul ? ST_MUL : ST_HOLD;
`else
        if (accept) state_nx = ST_HOLD;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            res_p1   <= '0;
            z_p1     <= 1'b0;
            dc_p1    <= 1'b0;
            c_p1     <= 1'b0;
            z_we_p1  <= 1'b0;
            dc_we_p1 <= 1'b0;
            c_we_p1  <= 1'b0;
            w_we_p1  <= 1'b0;
            f_we_p1  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_p1    <= '0;
            mcand_p1 <= '0;
            acc_p1   <= '0;
            cnt_p1   <= '0;
            st_p1    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            // capture stage: single-cycle results land directly in the output registers
            if (accept) begin
                w_we_p1  <= dest_wr_en & ~d;
                f_we_p1  <= dest_wr_en & d;
                res_p1   <= ev.res;
                z_p1     <= ev.z;
                dc_p1    <= ev.dc;
                c_p1     <= ev.c;
                z_we_p1  <= ev.z_we & status_wr_en;
                dc_we_p1 <= ev.dc_we & status_wr_en;
                c_we_p1  <= ev.c_we & status_wr_en;
`ifdef ALU_SEQ_MUL_EN
                hi_p1    <= '0;
                mcand_p1 <= op_lf;
                acc_p1   <= {{WIDTH{1'b0}}, op_w};
                cnt_p1   <= '0;
                st_p1    <= status_wr_en;
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            else if (state == ST_MUL) begin
                acc_p1 <= acc_nx;
                cnt_p1 <= cnt_p1 + CW'(1);
                if (mul_last) begin
                    res_p1   <= acc_nx[WIDTH-1:0];
                    hi_p1    <= acc_nx[2*WIDTH-1:WIDTH];
                    z_p1     <= (acc_nx == '0);
                    dc_p1    <= 1'b0;
                    c_p1     <= |acc_nx[2*WIDTH-1:WIDTH];
                    z_we_p1  <= st_p1;
                    dc_we_p1 <= 1'b0;
                    c_we_p1  <= st_p1;
                end
            end
`endif
        end
    end

    assign out_valid = (state == ST_HOLD);
    assign result    = res_p1;
    assign z         = z_p1;
    assign dc        = dc_p1;
    assign c         = c_p1;
    assign z_wr_en   = z_we_p1 & out_valid;
    assign dc_wr_en  = dc_we_p1 & out_valid;
    assign c_wr_en   = c_we_p1 & out_valid;
    assign w_wr_en   = w_we_p1 & out_valid;
    assign f_wr_en   = f_we_p1 & out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): scoreboard model plus directed literal vectors.
// Works with or without ALU_SEQ_MUL_EN defined.
module tb_alu_seq;
    localparam int WIDTH = 8;

    logic             clk = 1'b0, rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [3:0]       op = '0;
    logic [WIDTH-1:0] op_w = '0, op_lf = '0;
    logic             c_in = 1'b0, d = 1'b0, dest_wr_en = 1'b0, status_wr_en = 1'b0;
    logic             out_valid, out_ready = 1'b1;
    logic [WIDTH-1:0] result, result_hi;
    logic             w_wr_en, f_wr_en, z, dc, c, z_wr_en, dc_wr_en, c_wr_en;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .op_w(op_w), .op_lf(op_lf), .c_in(c_in), .d(d), .dest_wr_en(dest_wr_en),
        .status_wr_en(status_wr_en), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .w_wr_en(w_wr_en), .f_wr_en(f_wr_en),
        .z(z), .dc(dc), .c(c), .z_wr_en(z_wr_en), .dc_wr_en(dc_wr_en), .c_wr_en(c_wr_en)
    );

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] res, hi;
        bit z, dc, c, zwe, dcwe, cwe, wwe, fwe;
        int lat, acc;
    } exp_t;

    // Arithmetic model of one operation, written from the opcode rules with plain integers
    function automatic exp_t model(int o, int w, int lf, bit cin, bit dd, bit dest, bit st);
        exp_t e;
        int r, hi, p;
        bit wz, wdc, wc;
        r = 0; hi = 0; p = 0; wz = 0; wdc = 0; wc = 0;
        e.z = 0; e.dc = 0; e.c = 0; e.lat = 1; e.acc = 0;
        case (o)
            0:  begin r = (w + lf) % 256; e.c = (w + lf) > 255; e.dc = (w % 16 + lf % 16) > 15;
                      wz = 1; wdc = 1; wc = 1; end
            1:  begin r = w & lf; wz = 1; end
            2:  begin r = 0; wz = 1; end
            3:  begin r = 255 - lf; wz = 1; end
            4:  begin r = (lf + 255) % 256; wz = 1; end
            5:  begin r = (lf + 1) % 256; wz = 1; end
            6:  begin r = w | lf; wz = 1; end
            7:  begin r = lf; wz = 1; end
            8:  begin r = w; wz = 1; end
            9:  begin r = (lf * 2 + cin) % 256; e.c = (lf >= 128); wc = 1; end
            10: begin r = lf / 2 + (cin ? 128 : 0); e.c = (lf % 2) == 1; wc = 1; end
            11: begin r = (lf - w + 256) % 256; e.c = (lf >= w); e.dc = (lf % 16) >= (w % 16);
                      wz = 1; wdc = 1; wc = 1; end
            12: begin r = (lf % 16) * 16 + lf / 16; end
            13: begin r = w ^ lf; wz = 1; end
            14: begin
`ifdef ALU_SEQ_MUL_EN
                p = w * lf; r = p % 256; hi = p / 256; e.c = (hi != 0);
                wz = 1; wc = 1; e.lat = WIDTH + 1;
`endif
            end
            default: r = 0;
        endcase
        e.res = r[7:0];
        e.hi  = hi[7:0];
        e.z   = wz && (r == 0) && (hi == 0);
        e.zwe = st && wz; e.dcwe = st && wdc; e.cwe = st && wc;
        e.wwe = dest && !dd; e.fwe = dest && dd;
        return e;
    endfunction

    exp_t sb[$];
    bit   front_seen = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
            front_seen = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) chk("sb_unexpected_valid", 1, 0);
                else begin
                    e = sb[0];
                    if (!front_seen) begin
                        chk("sb_latency", cyc - e.acc, e.lat);
                        front_seen = 1;
                    end
                    chk("sb_outputs",
                        {result, result_hi, z, dc, c, z_wr_en, dc_wr_en, c_wr_en, w_wr_en, f_wr_en},
                        {e.res, e.hi, e.z, e.dc, e.c, e.zwe, e.dcwe, e.cwe, e.wwe, e.fwe});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        front_seen = 0;
                    end
                end
            end else begin
                chk("sb_idle_qualifiers", {z_wr_en, dc_wr_en, c_wr_en, w_wr_en, f_wr_en}, 0);
                if (sb.size() > 0) begin
                    chk("sb_busy_in_ready", in_ready, 0);
                    if (cyc > sb[0].acc + sb[0].lat) begin
                        chk("sb_late_valid", cyc - sb[0].acc, sb[0].lat);
                        void'(sb.pop_front());
                        front_seen = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(op, op_w, op_lf, c_in, d, dest_wr_en, status_wr_en);
                e.acc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic drive(input int o, input int w, input int lf, input bit cin, input bit dd,
                         input bit dest, input bit st);
        op = o[3:0]; op_w = w[7:0]; op_lf = lf[7:0]; c_in = cin; d = dd;
        dest_wr_en = dest; status_wr_en = st; in_valid = 1'b1;
    endtask

    // Present a request and return just after the edge that accepts it
    task automatic issue(input int o, input int w, input int lf, input bit cin, input bit dd,
                         input bit dest, input bit st);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        drive(o, w, lf, cin, dd, dest, st);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        bit ok;
        ok = 0; lat = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic expect_out(input string name, input logic [7:0] er, input logic [7:0] eh,
                              input bit ez, input bit edc, input bit ec,
                              input bit ezw, input bit edcw, input bit ecw);
        chk(name, {result_hi, result, z, dc, c, z_wr_en, dc_wr_en, c_wr_en},
                  {eh, er, ez, edc, ec, ezw, edcw, ecw});
    endtask

    typedef struct { int o, w, lf; bit cin, dd, dest, st; logic [7:0] er; bit ez; } vec_t;
    vec_t vecs[$];
    int lat;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {out_valid, result, result_hi, z, dc, c, z_wr_en, dc_wr_en, c_wr_en,
                              w_wr_en, f_wr_en}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        issue(0, 8'h0F, 8'h01, 0, 0, 1, 1);
        wait_valid(lat);
        chk("add_latency", lat, 1);
        expect_out("add_0f_01", 8'h10, 8'h00, 0, 1, 0, 1, 1, 1);
        chk("add_dest", {w_wr_en, f_wr_en}, 2'b10);

        issue(11, 8'h05, 8'h05, 0, 0, 1, 1);
        wait_valid(lat);
        expect_out("sub_equal", 8'h00, 8'h00, 1, 1, 1, 1, 1, 1);
        issue(11, 8'h05, 8'h04, 0, 0, 1, 1);
        wait_valid(lat);
        expect_out("sub_borrow", 8'hFF, 8'h00, 0, 0, 0, 1, 1, 1);

        issue(9, 8'h00, 8'h80, 1, 0, 1, 1);
        wait_valid(lat);
        expect_out("rlf_80", 8'h01, 8'h00, 0, 0, 1, 0, 0, 1);
        issue(10, 8'h00, 8'h01, 0, 0, 1, 1);
        wait_valid(lat);
        expect_out("rrf_01", 8'h00, 8'h00, 0, 0, 1, 0, 0, 1);

        issue(14, 8'hFF, 8'hFF, 0, 1, 1, 1);
        wait_valid(lat);
`ifdef ALU_SEQ_MUL_EN
        chk("mul_latency", lat, 9);
        expect_out("mul_ff_ff", 8'h01, 8'hFE, 0, 0, 1, 1, 0, 1);
`else
        chk("mul_off_latency", lat, 1);
        expect_out("mul_off", 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
`endif
        chk("mul_dest", {w_wr_en, f_wr_en}, 2'b01);

        // Backpressure: hold the result for 3 cycles, then retire and accept in one cycle
        @(posedge clk); #1 out_ready = 1'b0;
        issue(13, 8'hF0, 8'h3C, 0, 0, 1, 1);
        wait_valid(lat);
        @(posedge clk); #1;
        drive(6, 8'h01, 8'h02, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            expect_out("hold_stable", 8'hCC, 8'h00, 0, 0, 0, 1, 0, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        expect_out("b2b_or", 8'h03, 8'h00, 0, 0, 0, 1, 0, 0);

        vecs = '{
            '{1,  8'hF0, 8'h3C, 0, 0, 1, 1, 8'h30, 0},
            '{2,  8'h55, 8'h66, 0, 1, 1, 1, 8'h00, 1},
            '{3,  8'h00, 8'h0F, 0, 0, 1, 1, 8'hF0, 0},
            '{4,  8'h00, 8'h00, 0, 1, 1, 1, 8'hFF, 0},
            '{5,  8'h00, 8'hFF, 0, 0, 1, 1, 8'h00, 1},
            '{5,  8'h00, 8'h7F, 0, 0, 0, 1, 8'h80, 0},
            '{7,  8'h11, 8'h5A, 0, 0, 1, 1, 8'h5A, 0},
            '{8,  8'h33, 8'h44, 0, 1, 1, 0, 8'h33, 0},
            '{12, 8'h00, 8'hA5, 0, 0, 1, 1, 8'h5A, 0},
            '{15, 8'h12, 8'h34, 1, 1, 1, 1, 8'h00, 0},
            '{0,  8'h80, 8'h80, 0, 0, 1, 0, 8'h00, 1}
        };
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].w, vecs[i].lf, vecs[i].cin, vecs[i].dd, vecs[i].dest, vecs[i].st);
            wait_valid(lat);
            chk($sformatf("vec%0d_result", i), result, vecs[i].er);
            chk($sformatf("vec%0d_z", i), z, vecs[i].ez);
        end

        // Asynchronous reset while a result is being held
        @(posedge clk); #1 out_ready = 1'b0;
        issue(0, 8'h21, 8'h01, 0, 0, 1, 1);
        wait_valid(lat);
        expect_out("pre_reset_hold", 8'h22, 8'h00, 0, 0, 0, 1, 1, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("reset_hold_async", {out_valid, result, result_hi, z, dc, c, z_wr_en, dc_wr_en,
                                 c_wr_en, w_wr_en, f_wr_en}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;

`ifdef ALU_SEQ_MUL_EN
        issue(14, 8'h12, 8'h34, 0, 0, 1, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_mul_async", {out_valid, result, result_hi, z, dc, c, z_wr_en, dc_wr_en,
                                c_wr_en, w_wr_en, f_wr_en, in_ready}, 1);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
`endif

        issue(0, 8'h01, 8'h01, 0, 0, 1, 1);
        wait_valid(lat);
        chk("post_reset_latency", lat, 1);
        expect_out("post_reset_add", 8'h02, 8'h00, 0, 0, 0, 1, 1, 1);
        repeat (3) @(negedge clk);
        chk("final_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
